// File: rtl/ddr_axi_pkg.sv
// ddr_axi_pkg: AXI read-burst encodings and frame reader FSM states.
package ddr_axi_pkg;
    localparam logic [7:0]  AXI_LEN        = 8'd15;
    localparam logic [2:0]  AXI_SIZE       = 3'd4;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0]  LAST_BEAT      = 4'd15;
    localparam logic [31:0] BURST_BYTES    = 32'd256;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, NEXT} state_t;
endpackage

// File: rtl/frame_addr_gen.sv
// frame_addr_gen: line/burst counters and the byte address of the next burst.
module frame_addr_gen
    import ddr_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter logic [31:0] LINE_STRIDE     = 32'd5120,
    parameter int          BURSTS_PER_LINE = 20,
    parameter int          LINES           = 720
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] addr,
    output logic [15:0] line,
    output logic [15:0] burst,
    output logic        line_end,
    output logic        frame_end
);
    logic [31:0] line_base;
    assign line_end  = burst == 16'(BURSTS_PER_LINE - 1);
    assign frame_end = line == 16'(LINES - 1);
    // line_base tracks BASE_ADDR + line*LINE_STRIDE so no multiplier is needed
    always_ff @(posedge clk) begin
        if (!reset_n || load) begin
            line      <= '0;
            burst     <= '0;
            addr      <= BASE_ADDR;
            line_base <= BASE_ADDR;
        end else if (advance) begin
            if (line_end) begin
                burst     <= '0;
                line      <= line + 16'd1;
                line_base <= line_base + LINE_STRIDE;
                addr      <= line_base + LINE_STRIDE;
            end else begin
                burst <= burst + 16'd1;
                addr  <= addr + BURST_BYTES;
            end
        end
    end
endmodule

// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader: fetches a frame as 256-byte AXI read bursts and streams the beats out.
module ddr_frame_reader
    import ddr_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter logic [31:0] LINE_STRIDE     = 32'd5120,
    parameter int          BURSTS_PER_LINE = 20,
    parameter int          LINES           = 720,
    parameter logic [7:0]  RD_ID           = 8'h01
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         frame_start,
    output logic         busy,
    output logic         frame_done,
    output logic         err,
    output logic [7:0]   axi_aid,
    output logic [31:0]  axi_aaddr,
    output logic [7:0]   axi_alen,
    output logic [2:0]   axi_asize,
    output logic [1:0]   axi_aburst,
    output logic [1:0]   axi_alock,
    output logic         axi_atype,
    output logic         axi_avalid,
    input  logic         axi_aready,
    input  logic [7:0]   axi_rid,
    input  logic [127:0] axi_rdata,
    input  logic [1:0]   axi_rresp,
    input  logic         axi_rlast,
    input  logic         axi_rvalid,
    output logic         axi_rready,
    output logic [127:0] px_data,
    output logic         px_valid,
    input  logic         px_ready,
    output logic         px_sol,
    output logic         px_sof
);
    state_t      state, state_n;
    logic [3:0]  beat;
    logic [15:0] line, burst;
    logic        load, advance, acc, bad, line_end, frame_end;

    frame_addr_gen #(
        .BASE_ADDR(BASE_ADDR), .LINE_STRIDE(LINE_STRIDE),
        .BURSTS_PER_LINE(BURSTS_PER_LINE), .LINES(LINES)
    ) u_addr_gen (
        .clk(clk), .reset_n(reset_n), .load(load), .advance(advance),
        .addr(axi_aaddr), .line(line), .burst(burst),
        .line_end(line_end), .frame_end(frame_end)
    );

    assign axi_aid    = RD_ID;
    assign axi_alen   = AXI_LEN;
    assign axi_asize  = AXI_SIZE;
    assign axi_aburst = AXI_BURST_INCR;
    assign axi_alock  = 2'b00;
    assign axi_atype  = 1'b0;
    assign px_data    = axi_rdata;
    assign busy       = state != IDLE;
    assign acc        = state == DATA && axi_rvalid && px_ready;
    // a missing or early rlast counts as a protocol error and still closes the burst
    assign bad        = axi_rresp != AXI_RESP_OKAY || axi_rid != RD_ID || (axi_rlast != (beat == LAST_BEAT));
    assign px_sol     = state == DATA && axi_rvalid && beat == 4'd0 && burst == 16'd0;
    assign px_sof     = px_sol && line == 16'd0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            beat  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ADDR)
                beat <= '0;
            else if (acc)
                beat <= beat + 4'd1;
            if (acc && bad)
                err <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        load       = 1'b0;
        advance    = 1'b0;
        axi_avalid = 1'b0;
        axi_rready = 1'b0;
        px_valid   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                load    = frame_start;
                state_n = frame_start ? ADDR : IDLE;
            end
            ADDR: begin
                axi_avalid = 1'b1;
                state_n    = axi_aready ? DATA : ADDR;
            end
            DATA: begin
                axi_rready = px_ready;
                px_valid   = axi_rvalid;
                state_n    = (acc && (axi_rlast || bad)) ? NEXT : DATA;
            end
            NEXT: begin
                frame_done = line_end && frame_end;
                advance    = !frame_done;
                state_n    = frame_done ? IDLE : ADDR;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ddr_frame_reader.sv
// tb_ddr_frame_reader: directed checks of a 2x2-burst frame against a zero-wait AXI slave model.
module tb_ddr_frame_reader;
    localparam logic [7:0] RD = 8'h01;

    logic         clk = 1'b0;
    logic         reset_n, frame_start, busy, frame_done, err;
    logic [7:0]   axi_aid, axi_alen, axi_rid;
    logic [31:0]  axi_aaddr;
    logic [2:0]   axi_asize;
    logic [1:0]   axi_aburst, axi_alock, axi_rresp;
    logic         axi_atype, axi_avalid, axi_aready, axi_rlast, axi_rvalid, axi_rready;
    logic [127:0] axi_rdata, px_data;
    logic         px_valid, px_ready, px_sol, px_sof;

    int n_checks = 0;
    int n_errors = 0;
    int fd_count = 0;
    logic [31:0] seq = 0;
    logic [31:0] cons = 0;
    logic [31:0] addrs [4] = '{32'h1000, 32'h1100, 32'h1800, 32'h1900};
    int g_toggle = 0, g_aw = 0, g_fault = 0, g_fault_burst = -1, g_pulse_burst = -1;

    ddr_frame_reader #(
        .BASE_ADDR(32'h1000), .LINE_STRIDE(32'h800),
        .BURSTS_PER_LINE(2), .LINES(2), .RD_ID(RD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .busy(busy), .frame_done(frame_done), .err(err),
        .axi_aid(axi_aid), .axi_aaddr(axi_aaddr), .axi_alen(axi_alen),
        .axi_asize(axi_asize), .axi_aburst(axi_aburst), .axi_alock(axi_alock),
        .axi_atype(axi_atype), .axi_avalid(axi_avalid), .axi_aready(axi_aready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
        .px_sol(px_sol), .px_sof(px_sof)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (frame_done === 1'b1) fd_count++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic burst(input int i);
        int b, t, stop;
        logic f;
        f = g_fault_burst == i;
        stop = (f && g_fault == 1) ? 4 : (f && g_fault == 2) ? 8 : 16;
        t = 0;
        do begin
            @(negedge clk); #1; t++;
        end while (!axi_avalid && t < 20);
        check("avalid_up", axi_avalid, 1);
        check("aaddr", axi_aaddr, addrs[i]);
        for (int k = 0; k < g_aw; k++) begin
            @(negedge clk); #1;
            check("avalid_hold", axi_avalid, 1);
            check("aaddr_hold", axi_aaddr, addrs[i]);
        end
        if (g_pulse_burst == i) begin
            frame_start = 1'b1;
            @(negedge clk); #1;
            frame_start = 1'b0;
            check("start_ignored", axi_aaddr, addrs[i]);
        end
        axi_aready = 1'b1;
        @(negedge clk);
        axi_aready = 1'b0;
        b = 0;
        t = 0;
        while (b < stop && t < 100) begin
            px_ready   = g_toggle != 0 ? ~px_ready : 1'b1;
            axi_rvalid = 1'b1;
            axi_rdata  = {96'h0, seq};
            axi_rid    = RD;
            axi_rlast  = (f && g_fault == 2) ? (b == 7) : (b == 15);
            axi_rresp  = (f && g_fault == 1 && b == 3) ? 2'b10 : 2'b00;
            #1;
            check("rready_track", axi_rready, px_ready);
            check("px_valid", px_valid, 1);
            if (px_ready) begin
                check("px_data", px_data, {96'h0, cons});
                check("px_sol", px_sol, b == 0 && i % 2 == 0);
                check("px_sof", px_sof, b == 0 && i == 0);
                cons++;
            end
            if (axi_rready) begin
                b++;
                seq++;
            end
            @(negedge clk);
            t++;
        end
        check("burst_timeout", t < 100, 1);
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_rresp  = 2'b00;
        #1;
        check("frame_done", frame_done, i == 3);
    endtask

    task automatic run_frame(input int exp_beats, input logic exp_err);
        logic [31:0] c0;
        int f0;
        c0 = cons;
        f0 = fd_count;
        pulse_start();
        for (int i = 0; i < 4; i++) burst(i);
        @(negedge clk); #1;
        check("busy_end", busy, 0);
        check("px_beats", cons - c0, exp_beats);
        check("frame_done_cnt", fd_count - f0, 1);
        check("err", err, exp_err);
    endtask

    initial begin
        reset_n = 1'b0; frame_start = 1'b0; axi_aready = 1'b0; axi_rid = RD;
        axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b0; axi_rvalid = 1'b0; px_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_avalid", axi_avalid, 0);
        check("rst_rready", axi_rready, 0);
        check("rst_px_valid", px_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        check("const_ar", {axi_aid, axi_alen, axi_asize, axi_aburst, axi_alock, axi_atype},
              {8'h01, 8'd15, 3'd4, 2'b01, 2'b00, 1'b0});

        run_frame(64, 1'b0);
        g_toggle = 1;
        run_frame(64, 1'b0);
        g_toggle = 0;
        g_aw = 10;
        run_frame(64, 1'b0);
        g_aw = 0;
        g_fault = 1; g_fault_burst = 1;
        run_frame(52, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky", err, 1);
        g_fault = 0; g_fault_burst = -1;

        pulse_start();
        @(negedge clk);
        axi_aready = 1'b1;
        @(negedge clk);
        axi_aready = 1'b0;
        axi_rvalid = 1'b1;
        px_ready   = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rready", axi_rready, 0);
        check("mid_rst_px_valid", px_valid, 0);
        check("mid_rst_avalid", axi_avalid, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_frame_done", frame_done, 0);
        repeat (2) @(negedge clk);
        #1;
        check("post_rst_rready", axi_rready, 0);
        axi_rvalid = 1'b0;
        g_pulse_burst = 1;
        run_frame(64, 1'b0);
        g_pulse_burst = -1;

        g_fault = 2; g_fault_burst = 0;
        run_frame(56, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
